// File: rtl/mtm_alu_deserializer_p.sv
// Serial-to-parallel front end for the ALU: assembles B, A and a control byte from
// 11-bit frames, checks CRC4 as bits arrive, and reports operands or an error class.
//
// state   | meaning
// IDLE    | line idle, waiting for a start bit; inter-frame timeout runs mid-packet
// TYPE    | type bit sampled and checked against the expected frame kind
// PAYLOAD | eight payload bits shifted in MSB first
// STOP    | stop bit checked; data frame committed or packet completed
// SKIP    | discarding payload and stop of a frame with a bad type bit
module mtm_alu_deserializer_p #(
  parameter int DATA_BYTES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sin,
  output logic [8*DATA_BYTES-1:0] a,
  output logic [8*DATA_BYTES-1:0] b,
  output logic [2:0]              op,
  output logic                    out_valid,
  output logic [2:0]              err
);

  localparam int W   = 8 * DATA_BYTES;
  localparam int NFR = 2 * DATA_BYTES;
  localparam int BCW = $clog2(NFR + 1);
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BCW-1:0] DB_C     = BCW'(DATA_BYTES);
  localparam logic [BCW-1:0] NFR_C    = BCW'(NFR);
  localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT);

  localparam logic [2:0] ERR_DATA = 3'b001;
  localparam logic [2:0] ERR_CRC  = 3'b010;
  localparam logic [2:0] ERR_TMO  = 3'b100;

  typedef enum logic [2:0] {IDLE, TYPE, PAYLOAD, STOP, SKIP} state_t;

  state_t         state;
  logic [BCW-1:0] byte_cnt;
  logic [3:0]     bit_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic [3:0]     crc;
  logic [W-1:0]   b_sr;
  logic [W-1:0]   a_sr;
  logic [6:0]     ctl_sr;
  logic           tmo_en;
  logic           expire;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
  endfunction

  // tmo_cnt counts down from TIMEOUT; expiry is an IDLE cycle mid-packet with it at zero
  assign tmo_en = (TIMEOUT != 0);
  assign expire = tmo_en && (state == IDLE) && (byte_cnt != '0) && (tmo_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      bit_cnt   <= 4'd0;
      tmo_cnt   <= TMO_LOAD;
      crc       <= 4'h0;
      b_sr      <= '0;
      a_sr      <= '0;
      ctl_sr    <= '0;
      a         <= '0;
      b         <= '0;
      op        <= 3'b000;
      out_valid <= 1'b0;
      err       <= 3'b000;
    end else begin
      out_valid <= 1'b0;
      err       <= 3'b000;
      case (state)
        IDLE: begin
          if (expire) begin
            out_valid <= 1'b1;
            err       <= ERR_TMO;
            byte_cnt  <= '0;
          end
          if (expire || (!sin && byte_cnt == '0))
            crc <= 4'h0;
          if (!sin || expire || byte_cnt == '0)
            tmo_cnt <= TMO_LOAD;
          else if (tmo_en)
            tmo_cnt <= tmo_cnt - TW'(1);
          if (!sin)
            state <= TYPE;
        end

        TYPE: begin
          if ((byte_cnt < NFR_C && sin) || (byte_cnt == NFR_C && !sin)) begin
            out_valid <= 1'b1;
            err       <= ERR_DATA;
            byte_cnt  <= '0;
            bit_cnt   <= 4'd8;
            state     <= SKIP;
          end else begin
            bit_cnt <= 4'd7;
            state   <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (byte_cnt < DB_C)
            b_sr <= {b_sr[W-2:0], sin};
          else if (byte_cnt < NFR_C)
            a_sr <= {a_sr[W-2:0], sin};
          else if (bit_cnt != 4'd7)
            ctl_sr <= {ctl_sr[5:0], sin};
          // ctl bit 7 is reserved; the CRC sees an implicit 1 in its place before op
          if (byte_cnt != NFR_C)
            crc <= crc_step(crc, sin);
          else if (bit_cnt == 4'd7)
            crc <= crc_step(crc, 1'b1);
          else if (bit_cnt >= 4'd4)
            crc <= crc_step(crc, sin);
          if (bit_cnt == 4'd0)
            state <= STOP;
          else
            bit_cnt <= bit_cnt - 4'd1;
        end

        STOP: begin
          state <= IDLE;
          if (!sin) begin
            out_valid <= 1'b1;
            err       <= ERR_DATA;
            byte_cnt  <= '0;
          end else if (byte_cnt < NFR_C) begin
            byte_cnt <= byte_cnt + BCW'(1);
          end else begin
            out_valid <= 1'b1;
            byte_cnt  <= '0;
            if (crc == ctl_sr[3:0]) begin
              a  <= a_sr;
              b  <= b_sr;
              op <= ctl_sr[6:4];
            end else begin
              err <= ERR_CRC;
            end
          end
        end

        SKIP: begin
          if (bit_cnt == 4'd0)
            state <= IDLE;
          else
            bit_cnt <= bit_cnt - 4'd1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer_p.sv
// Directed bench for mtm_alu_deserializer_p: a scoreboard queue of expected reports for
// the main instance, plus directed checks on a no-timeout and a two-byte instance.
module tb_mtm_alu_deserializer_p;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sin4 = 1'b1, sin0 = 1'b1, sin2 = 1'b1;

  logic [31:0] a4, b4, a0, b0;
  logic [15:0] a2, b2;
  logic [2:0]  op4, op0, op2, err4, err0, err2;
  logic        ov4, ov0, ov2;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mtm_alu_deserializer_p #(.DATA_BYTES(4), .TIMEOUT(20)) u4 (
    .clk(clk), .rst(rst), .sin(sin4), .a(a4), .b(b4), .op(op4), .out_valid(ov4), .err(err4));
  mtm_alu_deserializer_p #(.DATA_BYTES(4), .TIMEOUT(0)) u0 (
    .clk(clk), .rst(rst), .sin(sin0), .a(a0), .b(b0), .op(op0), .out_valid(ov0), .err(err0));
  mtm_alu_deserializer_p #(.DATA_BYTES(2), .TIMEOUT(20)) u2 (
    .clk(clk), .rst(rst), .sin(sin2), .a(a2), .b(b2), .op(op2), .out_valid(ov2), .err(err2));

  typedef struct packed {
    logic [2:0]  err;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    int          cyc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  mon_e;
  string mon_t;

  logic [31:0] good_a = '0, good_b = '0;
  logic [2:0]  good_op = '0;

  int          cnt0 = 0, cnt2 = 0, cyc2_l = 0;
  logic [2:0]  err0_l = '0, err2_l = '0, op2_l = '0;
  logic [31:0] a0_l = '0;
  logic [15:0] a2_l = '0, b2_l = '0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic expect_rpt(string tag, logic [2:0] e, int c);
    exp_q.push_back('{err: e, a: good_a, b: good_b, op: good_op, cyc: c});
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    if (ov4) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_strobe: observed err=%b at cycle %0d expected no report", err4, cyc);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        check({mon_t, "_err"}, 64'(err4), 64'(mon_e.err));
        check({mon_t, "_a"}, 64'(a4), 64'(mon_e.a));
        check({mon_t, "_b"}, 64'(b4), 64'(mon_e.b));
        check({mon_t, "_op"}, 64'(op4), 64'(mon_e.op));
        check({mon_t, "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  always @(negedge clk) if (ov0) begin cnt0++; err0_l = err0; a0_l = a0; end
  always @(negedge clk)
    if (ov2) begin cnt2++; err2_l = err2; a2_l = a2; b2_l = b2; op2_l = op2; cyc2_l = cyc; end

  // Reference CRC by polynomial long division of the message times x^4 by x^4+x+1
  function automatic logic [3:0] crc_ref(logic [63:0] bv, logic [63:0] av, logic [2:0] opv, int nb);
    logic [139:0] m;
    int n;
    m = '0;
    n = 0;
    for (int i = 8*nb-1; i >= 0; i--) begin m = {m[138:0], bv[i]}; n++; end
    for (int i = 8*nb-1; i >= 0; i--) begin m = {m[138:0], av[i]}; n++; end
    m = {m[138:0], 1'b1}; n++;
    for (int i = 2; i >= 0; i--) begin m = {m[138:0], opv[i]}; n++; end
    m = m << 4;
    n += 4;
    for (int i = n-1; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  function automatic logic [7:0] ctl_byte(logic [63:0] bv, logic [63:0] av, logic [2:0] opv, int nb);
    return {1'b0, opv, crc_ref(bv, av, opv, nb)};
  endfunction

  function automatic logic [7:0] frame_byte(logic [63:0] bv, logic [63:0] av, int nb, int k);
    return (k < nb) ? bv[8*(nb-1-k) +: 8] : av[8*(2*nb-1-k) +: 8];
  endfunction

  task automatic drive(int sel, logic v);
    @(negedge clk);
    if (sel == 0) sin4 = v;
    else if (sel == 1) sin0 = v;
    else sin2 = v;
  endtask

  task automatic idle(int sel, int n);
    for (int i = 0; i < n; i++) drive(sel, 1'b1);
  endtask

  task automatic send_frame(int sel, logic typ, logic [7:0] pl, logic stp,
                            output int t_start, output int t_type, output int t_stop);
    drive(sel, 1'b0); t_start = cyc;
    drive(sel, typ);  t_type = cyc;
    for (int i = 7; i >= 0; i--) drive(sel, pl[i]);
    drive(sel, stp);  t_stop = cyc;
  endtask

  task automatic send_data(int sel, int nb, logic [63:0] bv, logic [63:0] av,
                           int first, int last, output int t_stop);
    int ts, tt;
    t_stop = cyc;
    for (int k = first; k <= last; k++)
      send_frame(sel, 1'b0, frame_byte(bv, av, nb, k), 1'b1, ts, tt, t_stop);
  endtask

  task automatic send_ctl(int sel, logic [7:0] ctl, output int t_start);
    int tt, tp;
    send_frame(sel, 1'b1, ctl, 1'b1, t_start, tt, tp);
  endtask

  task automatic send_packet(int sel, int nb, logic [63:0] bv, logic [63:0] av,
                             logic [7:0] ctl, output int t_ctl);
    int ts;
    send_data(sel, nb, bv, av, 0, 2*nb-1, ts);
    send_ctl(sel, ctl, t_ctl);
  endtask

  task automatic good4(string tag, logic [31:0] bv, logic [31:0] av, logic [2:0] opv);
    int tc;
    send_packet(0, 4, 64'(bv), 64'(av), ctl_byte(64'(bv), 64'(av), opv, 4), tc);
    good_a = av;
    good_b = bv;
    good_op = opv;
    expect_rpt(tag, 3'b000, tc + 11);
  endtask

  initial begin
    int tc, ts, t0, tt, tp;
    logic [31:0] rb, ra;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("rst_a", 64'(a4), 64'h0);
    check("rst_b", 64'(b4), 64'h0);
    check("rst_op", 64'(op4), 64'h0);
    check("rst_valid", 64'(ov4), 64'h0);
    check("rst_err", 64'(err4), 64'h0);
    check("rst_a2", 64'(a2), 64'h0);

    send_packet(0, 4, 64'h0, 64'h0, 8'h0B, tc);
    expect_rpt("ok_zero", 3'b000, tc + 11);
    send_packet(0, 4, 64'h0, 64'h0, 8'h0A, tc);
    expect_rpt("crc_zero", 3'b010, tc + 11);
    idle(0, 2);

    good4("opnd1", 32'h12345678, 32'h9ABCDEF0, 3'd5);
    good4("opnd2", 32'h12345678, 32'h9ABCDEF0, 3'd5);
    for (int i = 0; i < 3; i++) begin
      rb = $urandom;
      ra = $urandom;
      good4("rand", rb, ra, 3'($urandom_range(0, 7)));
    end

    send_packet(0, 4, 64'hDEADBEEF, 64'h0, ctl_byte(64'hDEADBEEF, 64'h0, 3'd1, 4) ^ 8'h01, tc);
    expect_rpt("crc_hold", 3'b010, tc + 11);
    idle(0, 3);

    send_data(0, 4, 64'h11223344, 64'h55667788, 0, 2, ts);
    expect_rpt("type_early", 3'b001, ts + 3);
    send_ctl(0, 8'h0B, tc);
    good4("after_type", 32'hCAFEF00D, 32'h0BADBEEF, 3'd2);

    send_data(0, 4, 64'h01020304, 64'h05060708, 0, 0, ts);
    expect_rpt("stop_bad", 3'b001, ts + 12);
    send_frame(0, 1'b0, 8'h02, 1'b0, t0, tt, tp);
    idle(0, 3);
    good4("after_stop", 32'h00FF00FF, 32'hFF00FF00, 3'd7);

    send_data(0, 4, 64'hAAAA5555, 64'h5555AAAA, 0, 2, ts);
    expect_rpt("timeout", 3'b100, ts + 22);
    idle(0, 21);
    good4("after_tmo", 32'h13579BDF, 32'h2468ACE0, 3'd3);

    send_data(0, 4, 64'h0, 64'h0, 0, 2, ts);
    expect_rpt("tmo_restart", 3'b100, ts + 22);
    idle(0, 20);
    good4("restart_pkt", 32'h76543210, 32'hFEDCBA98, 3'd6);

    send_data(0, 4, 64'h31415926, 64'h27182818, 0, 2, ts);
    idle(0, 19);
    send_data(0, 4, 64'h31415926, 64'h27182818, 3, 7, ts);
    send_ctl(0, ctl_byte(64'h31415926, 64'h27182818, 3'd4, 4), tc);
    good_a = 32'h27182818;
    good_b = 32'h31415926;
    good_op = 3'd4;
    expect_rpt("gap19", 3'b000, tc + 11);

    send_data(0, 4, 64'h1, 64'h2, 0, 7, ts);
    expect_rpt("extra_frame", 3'b001, ts + 3);
    send_frame(0, 1'b0, 8'h5A, 1'b1, t0, tt, tp);
    idle(0, 3);

    send_data(0, 4, 64'h89ABCDEF, 64'h01234567, 0, 7, ts);
    drive(0, 1'b0);
    drive(0, 1'b1);
    drive(0, 1'b0);
    drive(0, 1'b1);
    drive(0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    sin4 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    good_a = '0;
    good_b = '0;
    good_op = '0;
    check("midrst_a", 64'(a4), 64'h0);
    check("midrst_b", 64'(b4), 64'h0);
    check("midrst_op", 64'(op4), 64'h0);
    good4("after_rst", 32'h0F1E2D3C, 32'h4B5A6978, 3'd1);
    idle(0, 3);

    send_data(1, 4, 64'h10203040, 64'h50607080, 0, 2, ts);
    idle(1, 60);
    check("notmo_quiet", 64'(cnt0), 64'd0);
    send_data(1, 4, 64'h10203040, 64'h50607080, 3, 7, ts);
    send_ctl(1, ctl_byte(64'h10203040, 64'h50607080, 3'd2, 4), tc);
    idle(1, 3);
    check("notmo_count", 64'(cnt0), 64'd1);
    check("notmo_err", 64'(err0_l), 64'h0);
    check("notmo_a", 64'(a0_l), 64'h50607080);

    send_packet(2, 2, 64'h0, 64'h0, ctl_byte(64'h0, 64'h0, 3'd0, 2), tc);
    idle(2, 3);
    check("db2_count", 64'(cnt2), 64'd1);
    check("db2_err", 64'(err2_l), 64'h0);
    check("db2_a", 64'(a2_l), 64'h0);
    check("db2_cycle", 64'(cyc2_l), 64'(tc + 11));
    send_packet(2, 2, 64'hBEEF, 64'h1234, ctl_byte(64'hBEEF, 64'h1234, 3'd3, 2), tc);
    idle(2, 3);
    check("db2_count2", 64'(cnt2), 64'd2);
    check("db2_a2", 64'(a2_l), 64'h1234);
    check("db2_b2", 64'(b2_l), 64'hBEEF);
    check("db2_op2", 64'(op2_l), 64'h3);
    check("db2_err2", 64'(err2_l), 64'h0);

    idle(0, 30);
    check("pending_reports", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
